// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: loads program words into instruction memory,
// then runs fetch with stall/flush/step control until a HALT opcode is fetched.
module if_fetch_ctrl #(
   parameter int unsigned        PC_SZ   = 32,
   parameter int unsigned        INST_SZ = 32,
   parameter int unsigned        W       = 5,
   parameter logic [INST_SZ-1:0] HALT_OP = '1
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_load_valid,
   input  logic [INST_SZ-1:0] i_load_data,
   input  logic               i_load_done,
   input  logic               i_step_mode,
   input  logic               i_step,
   input  logic               i_stall,
   input  logic               i_flush,
   input  logic [1:0]         i_pc_src,
   input  logic [PC_SZ-1:0]   i_branch_addr,
   input  logic [PC_SZ-1:0]   i_jump_addr,
   input  logic [INST_SZ-1:0] i_mem_data,
   output logic               o_mem_write,
   output logic [PC_SZ-1:0]   o_mem_addr,
   output logic [INST_SZ-1:0] o_mem_wdata,
   output logic [PC_SZ-1:0]   o_pc,
   output logic [INST_SZ-1:0] o_instr,
   output logic [PC_SZ-1:0]   o_pc_next,
   output logic               o_halted,
   output logic [1:0]         o_state
);

   typedef enum logic [1:0] {
      ST_LOAD = 2'b00,
      ST_RUN  = 2'b01,
      ST_HALT = 2'b10
   } state_e;

   localparam logic [PC_SZ-1:0] PC_STEP    = PC_SZ'(4);
   localparam logic [PC_SZ-1:0] ALIGN_MASK = ~PC_SZ'(3);

   state_e             state_q, state_d;
   logic [W-1:0]       load_ptr_q, load_ptr_d;
   logic [PC_SZ-1:0]   pc_q, pc_d;
   logic [PC_SZ-1:0]   pc_next_q, pc_next_d;
   logic [INST_SZ-1:0] instr_q, instr_d;
   logic               halted_q, halted_d;

   logic               advance_c;
   logic               load_wr_c;
   logic [PC_SZ-1:0]   pc_plus4_c;
   logic [PC_SZ-1:0]   target_c;

   assign advance_c  = !i_stall && (!i_step_mode || i_step);
   assign pc_plus4_c = pc_q + PC_STEP;

   // Next-PC select; branch/jump targets are forced word-aligned.
   always_comb begin
      target_c = pc_plus4_c;
      unique case (i_pc_src)
         2'b01:   target_c = i_branch_addr & ALIGN_MASK;
         2'b10:   target_c = i_jump_addr & ALIGN_MASK;
         default: target_c = pc_plus4_c;
      endcase
   end

   // Next-state and register-update logic.
   always_comb begin
      state_d    = state_q;
      load_ptr_d = load_ptr_q;
      pc_d       = pc_q;
      pc_next_d  = pc_next_q;
      instr_d    = instr_q;
      halted_d   = halted_q;

      unique case (state_q)
         ST_LOAD: begin
            if (i_load_valid) begin
               load_ptr_d = load_ptr_q + W'(1);
            end
            if (i_load_done) begin
               state_d    = ST_RUN;
               load_ptr_d = '0;
               pc_d       = '0;
            end
         end
         ST_RUN: begin
            // Flush squashes IF/ID even while stalled.
            if (i_flush) begin
               instr_d = '0;
            end
            if (advance_c) begin
               pc_next_d = pc_plus4_c;
               if (!i_flush && (i_mem_data == HALT_OP)) begin
                  state_d  = ST_HALT;
                  halted_d = 1'b1;
                  instr_d  = HALT_OP;
               end else begin
                  pc_d = target_c;
                  if (!i_flush) begin
                     instr_d = i_mem_data;
                  end
               end
            end
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_LOAD;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q    <= ST_LOAD;
         load_ptr_q <= '0;
         pc_q       <= '0;
         pc_next_q  <= '0;
         instr_q    <= '0;
         halted_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         load_ptr_q <= load_ptr_d;
         pc_q       <= pc_d;
         pc_next_q  <= pc_next_d;
         instr_q    <= instr_d;
         halted_q   <= halted_d;
      end
   end

   // Memory port is combinational so a loader word is written in its own cycle;
   // reset gates the strobe so nothing is written while reset is held.
   assign load_wr_c   = i_reset && (state_q == ST_LOAD) && i_load_valid;
   assign o_mem_write = load_wr_c;
   assign o_mem_wdata = load_wr_c ? i_load_data : '0;
   assign o_mem_addr  = (state_q == ST_LOAD) ? PC_SZ'({load_ptr_q, 2'b00}) : pc_q;

   assign o_pc      = pc_q;
   assign o_instr   = instr_q;
   assign o_pc_next = pc_next_q;
   assign o_halted  = halted_q;
   assign o_state   = state_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Scoreboard bench for if_fetch_ctrl: stimulus pushes expected writes and
// post-edge snapshots; a negedge monitor pops and compares them.
module tb_if_fetch_ctrl;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic        i_load_valid;
   logic [31:0] i_load_data;
   logic        i_load_done;
   logic        i_step_mode;
   logic        i_step;
   logic        i_stall;
   logic        i_flush;
   logic [1:0]  i_pc_src;
   logic [31:0] i_branch_addr;
   logic [31:0] i_jump_addr;
   logic [31:0] i_mem_data;
   logic        o_mem_write;
   logic [31:0] o_mem_addr;
   logic [31:0] o_mem_wdata;
   logic [31:0] o_pc;
   logic [31:0] o_instr;
   logic [31:0] o_pc_next;
   logic        o_halted;
   logic [1:0]  o_state;

   if_fetch_ctrl dut (
      .i_clk(i_clk), .i_reset(i_reset),
      .i_load_valid(i_load_valid), .i_load_data(i_load_data), .i_load_done(i_load_done),
      .i_step_mode(i_step_mode), .i_step(i_step), .i_stall(i_stall), .i_flush(i_flush),
      .i_pc_src(i_pc_src), .i_branch_addr(i_branch_addr), .i_jump_addr(i_jump_addr),
      .i_mem_data(i_mem_data),
      .o_mem_write(o_mem_write), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
      .o_pc(o_pc), .o_instr(o_instr), .o_pc_next(o_pc_next),
      .o_halted(o_halted), .o_state(o_state)
   );

   always #5 i_clk = ~i_clk;

   // Instruction memory behind the DUT's port, with a one-cycle data override.
   logic [31:0] imem [32];
   logic        ovr_en;
   logic [31:0] ovr_val;
   always @(posedge i_clk) if (o_mem_write) imem[o_mem_addr[6:2]] <= o_mem_wdata;
   assign i_mem_data = ovr_en ? ovr_val : imem[o_pc[6:2]];

   typedef struct {
      logic [31:0] pc, instr, pcn, addr;
      logic [1:0]  st;
      logic        h, ca;
      int          due;
   } snap_t;
   typedef struct { logic [31:0] addr, data; } wr_t;

   snap_t sq[$];
   string nq[$];
   wr_t   wq[$];
   int    cyc = 0;
   int    n_tests = 0;
   int    n_fail = 0;

   always @(posedge i_clk) cyc <= cyc + 1;

   function automatic void push_snap(input string nm, input int due, input logic [31:0] pc,
                                     input logic [31:0] instr, input logic [31:0] pcn,
                                     input logic [1:0] st, input logic h, input logic ca);
      snap_t s;
      s.pc = pc; s.instr = instr; s.pcn = pcn; s.addr = pc;
      s.st = st; s.h = h; s.ca = ca; s.due = due;
      sq.push_back(s);
      nq.push_back(nm);
   endfunction

   function automatic void exp_run(input string nm, input logic [31:0] pc,
                                   input logic [31:0] instr, input logic [31:0] pcn);
      push_snap(nm, cyc + 1, pc, instr, pcn, 2'b01, 1'b0, 1'b1);
   endfunction

   function automatic void exp_halt(input string nm, input logic [31:0] pc,
                                    input logic [31:0] instr, input logic [31:0] pcn);
      push_snap(nm, cyc + 1, pc, instr, pcn, 2'b10, 1'b1, 1'b0);
   endfunction

   // Checked at this cycle's negedge, before any further clock edge.
   function automatic void exp_reset(input string nm);
      push_snap(nm, cyc, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b1);
   endfunction

   function automatic void push_wr(input logic [31:0] addr, input logic [31:0] data);
      wr_t w;
      w.addr = addr; w.data = data;
      wq.push_back(w);
   endfunction

   // Monitor: writes are checked whenever the strobe is seen; snapshots when due.
   wr_t   mw;
   snap_t ms;
   string mn;
   logic  mok;
   always @(negedge i_clk) begin
      if (o_mem_write) begin
         n_tests++;
         if (wq.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_write cyc=%0d addr=%h data=%h", cyc, o_mem_addr, o_mem_wdata);
         end else begin
            mw = wq.pop_front();
            if (o_mem_addr !== mw.addr || o_mem_wdata !== mw.data) begin
               n_fail++;
               $display("FAIL mem_write cyc=%0d got addr=%h data=%h exp addr=%h data=%h",
                        cyc, o_mem_addr, o_mem_wdata, mw.addr, mw.data);
            end
         end
      end
      while (sq.size() > 0 && sq[0].due <= cyc) begin
         ms = sq.pop_front();
         mn = nq.pop_front();
         n_tests++;
         mok = (o_pc === ms.pc) && (o_instr === ms.instr) && (o_pc_next === ms.pcn) &&
               (o_state === ms.st) && (o_halted === ms.h) && (o_mem_write === 1'b0) &&
               (!ms.ca || (o_mem_addr === ms.addr));
         if (!mok) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got pc=%h instr=%h pcn=%h st=%0d halt=%b wr=%b addr=%h exp pc=%h instr=%h pcn=%h st=%0d halt=%b wr=0 addr=%h",
                     mn, cyc, o_pc, o_instr, o_pc_next, o_state, o_halted, o_mem_write, o_mem_addr,
                     ms.pc, ms.instr, ms.pcn, ms.st, ms.h, ms.addr);
         end
      end
   end

   task automatic cycle();
      @(posedge i_clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired at cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      i_reset = 1'b0; i_load_valid = 1'b0; i_load_data = '0; i_load_done = 1'b0;
      i_step_mode = 1'b0; i_step = 1'b0; i_stall = 1'b0; i_flush = 1'b0;
      i_pc_src = 2'b00; i_branch_addr = '0; i_jump_addr = '0;
      ovr_en = 1'b0; ovr_val = '0;
      cycle(); cycle();
      exp_reset("reset_init");
      cycle();
      i_reset = 1'b1;
      cycle();

      // 34 loader words: 0..31, then the pointer wraps onto addresses 0 and 4
      for (int i = 0; i < 34; i++) begin
         i_load_valid = 1'b1;
         i_load_data  = 32'(i % 32);
         push_wr(32'((i % 32) * 4), 32'(i % 32));
         cycle();
      end
      i_load_valid = 1'b0; i_load_done = 1'b1;
      exp_run("load_done", 32'h0, 32'h0, 32'h0);
      cycle();
      i_load_done = 1'b0;

      // free run: instr lags pc by one word
      for (int k = 0; k < 4; k++) begin
         exp_run("free_run", 32'(4 * (k + 1)), 32'(k), 32'(4 * (k + 1)));
         cycle();
      end

      // stall at 0x10 (loader strobes must be ignored outside LOAD)
      i_stall = 1'b1; i_load_valid = 1'b1; i_load_data = 32'hDEAD_BEEF;
      for (int k = 0; k < 3; k++) begin
         exp_run("stall_hold", 32'h10, 32'h3, 32'h10);
         cycle();
      end
      i_stall = 1'b0; i_load_valid = 1'b0;
      exp_run("stall_resume", 32'h14, 32'h4, 32'h14); cycle();
      exp_run("run_0x18", 32'h18, 32'h5, 32'h18); cycle();

      i_pc_src = 2'b01; i_branch_addr = 32'h43; i_flush = 1'b1;
      exp_run("branch_flush", 32'h40, 32'h0, 32'h1C); cycle();
      i_pc_src = 2'b00; i_flush = 1'b0;
      exp_run("after_branch", 32'h44, 32'h10, 32'h44); cycle();
      i_pc_src = 2'b10; i_jump_addr = 32'h6;
      exp_run("jump_align", 32'h04, 32'h11, 32'h48); cycle();
      i_pc_src = 2'b11;
      exp_run("src11_pc4", 32'h08, 32'h1, 32'h08); cycle();
      i_pc_src = 2'b00; i_stall = 1'b1; i_flush = 1'b1;
      exp_run("flush_in_stall", 32'h08, 32'h0, 32'h08); cycle();
      i_stall = 1'b0; ovr_en = 1'b1; ovr_val = 32'hFFFF_FFFF;
      exp_run("flush_masks_halt", 32'h0C, 32'h0, 32'h0C); cycle();
      i_flush = 1'b0; ovr_en = 1'b0;

      // single-step mode
      i_step_mode = 1'b1; i_step = 1'b0;
      for (int k = 0; k < 2; k++) begin
         exp_run("step_idle", 32'h0C, 32'h0, 32'h0C);
         cycle();
      end
      i_step = 1'b1;
      exp_run("step_one", 32'h10, 32'h3, 32'h10); cycle();
      i_step = 1'b0;
      exp_run("step_hold", 32'h10, 32'h3, 32'h10); cycle();
      i_step = 1'b1; i_pc_src = 2'b10; i_jump_addr = 32'h8;
      exp_run("step_jump", 32'h08, 32'h4, 32'h14); cycle();
      i_pc_src = 2'b00; ovr_en = 1'b1; ovr_val = 32'hFFFF_FFFF;
      exp_halt("halt_entry", 32'h08, 32'hFFFF_FFFF, 32'h0C); cycle();
      ovr_en = 1'b0; i_step_mode = 1'b0; i_pc_src = 2'b01; i_branch_addr = 32'h20;
      i_flush = 1'b1; i_load_valid = 1'b1;
      for (int k = 0; k < 2; k++) begin
         exp_halt("halt_frozen", 32'h08, 32'hFFFF_FFFF, 32'h0C);
         cycle();
      end
      cycle();

      // asynchronous reset out of HALT, observed before the next clock edge
      i_reset = 1'b0; i_load_valid = 1'b0; i_flush = 1'b0; i_pc_src = 2'b00;
      exp_reset("reset_from_halt");
      cycle();
      i_reset = 1'b1;
      for (int i = 0; i < 7; i++) begin
         i_load_valid = 1'b1;
         i_load_data  = 32'h100 + 32'(i);
         push_wr(32'(i * 4), 32'h100 + 32'(i));
         cycle();
      end
      // reset lands while word 7 is being presented
      i_load_data = 32'h107; i_reset = 1'b0;
      exp_reset("reset_midload");
      cycle();
      i_load_valid = 1'b0;
      cycle();
      i_reset = 1'b1; i_load_valid = 1'b1; i_load_data = 32'hA0;
      push_wr(32'h0, 32'hA0);
      cycle();
      i_load_data = 32'hA1; i_load_done = 1'b1;
      push_wr(32'h4, 32'hA1);
      exp_run("reload_done", 32'h0, 32'h0, 32'h0);
      cycle();
      i_load_valid = 1'b0; i_load_done = 1'b0;
      exp_run("reload_fetch0", 32'h4, 32'hA0, 32'h4); cycle();
      exp_run("reload_fetch1", 32'h8, 32'hA1, 32'h8); cycle();
      cycle();

      n_tests++;
      if (wq.size() != 0 || sq.size() != 0) begin
         n_fail++;
         $display("FAIL leftover_expectations got writes=%0d snaps=%0d exp 0", wq.size(), sq.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/if_fetch_ctrl.md
IF_FETCH_CTRL -- requirements
Module: if_fetch_ctrl

Interface
REQ-001 Parameter PC_SZ, default 32, program counter width in bits.
REQ-002 Parameter INST_SZ, default 32, instruction width in bits.
REQ-003 Parameter W, default 5, instruction memory word-address width (depth 2^W words).
REQ-004 Parameter HALT_OP, default all ones, instruction encoding that stops fetch.
REQ-005 The clock port SHALL be i_clk; all sequential logic is in this one clock domain.
REQ-006 The reset port SHALL be i_reset, asynchronous and active-low.
REQ-007 Data ports (name, direction, width, meaning):
- i_load_valid, in, 1: loader word present.
- i_load_data, in, INST_SZ: loader instruction word.
- i_load_done, in, 1: loader finished; start execution.
- i_step_mode, in, 1: 1 means advance only on i_step.
- i_step, in, 1: single-cycle step pulse.
- i_stall, in, 1: hold PC and IF/ID.
- i_flush, in, 1: replace IF/ID with NOP.
- i_pc_src, in, 2: next-PC select (00 PC+4, 01 branch, 10 jump, 11 PC+4).
- i_branch_addr, in, PC_SZ: branch target.
- i_jump_addr, in, PC_SZ: jump target.
- i_mem_data, in, INST_SZ: combinational instruction memory read data.
- o_mem_write, out, 1: instruction memory write enable.
- o_mem_addr, out, PC_SZ: instruction memory address (byte address).
- o_mem_wdata, out, INST_SZ: instruction memory write data.
- o_pc, out, PC_SZ: current PC.
- o_instr, out, INST_SZ: IF/ID instruction.
- o_pc_next, out, PC_SZ: IF/ID PC+4.
- o_halted, out, 1: HALT state.
- o_state, out, 2: 00 LOAD, 01 RUN, 10 HALT.

Function
REQ-008 The FSM SHALL have states LOAD, RUN and HALT, and SHALL enter LOAD on reset.
REQ-009 In LOAD, each cycle with i_load_valid=1 SHALL assert o_mem_write for that cycle, drive o_mem_wdata=i_load_data, drive o_mem_addr=load_ptr*4, and increment load_ptr by one.
REQ-010 load_ptr SHALL be W bits wide and SHALL wrap from 2^W-1 to 0; a write at the wrapped address overwrites the old word.
REQ-011 In LOAD, i_load_done=1 SHALL move the FSM to RUN on the next edge, clear PC to 0, and clear load_ptr to 0; a simultaneous i_load_valid word SHALL still be written.
REQ-012 o_mem_write SHALL be 0 in every state other than LOAD.
REQ-013 In RUN, o_mem_addr SHALL equal o_pc.
REQ-014 In RUN, an advance occurs when i_stall=0 and (i_step_mode=0 or i_step=1).
REQ-015 On an advance, PC SHALL load the value selected by i_pc_src; o_instr SHALL load i_mem_data and o_pc_next SHALL load o_pc+4, both modulo 2^PC_SZ.
REQ-016 When no advance occurs, PC, o_instr and o_pc_next SHALL hold their values.
REQ-017 i_flush=1 SHALL load o_instr=0 (NOP) regardless of i_stall; PC SHALL follow REQ-014 and REQ-015.
REQ-018 On an advance where i_mem_data==HALT_OP and i_flush=0, the FSM SHALL move to HALT, latch HALT_OP into o_instr, and not update PC.
REQ-019 In HALT, PC and IF/ID SHALL be frozen, o_halted=1, and the only exit SHALL be reset.
REQ-020 Latency: the instruction at address A SHALL appear on o_instr one clock after the advance edge with o_pc=A.
REQ-021 PC bits [1:0] SHALL be forced to 0 when a branch or jump target is loaded.

Reset
REQ-022 Asserting i_reset low SHALL immediately, without waiting for a clock, set: state LOAD, load_ptr 0, o_pc 0, o_instr 0, o_pc_next 0, o_mem_write 0, o_halted 0.
REQ-023 Reset asserted in any state, including mid-load, SHALL discard progress; loading restarts at word 0 after release.
REQ-024 The first clock edge after i_reset returns high SHALL be a normal LOAD-state edge.

Verification
REQ-025 Load 32 words 0..31 then pulse i_load_done -> 32 writes at addresses 0,4,...,124 with data equal to the index; state RUN; o_pc=0.
REQ-026 Free run with i_mem_data=addr/4 -> o_instr sequence 0,1,2,... one cycle behind o_pc; o_pc_next=o_pc_prev+4.
REQ-027 i_stall for 3 cycles at o_pc=0x10 -> o_pc stays 0x10 and o_instr holds; resumes at 0x14.
REQ-028 i_pc_src=01 with i_branch_addr=0x43 plus i_flush -> o_pc=0x40 and o_instr=0 next cycle.
REQ-029 i_step_mode=1 with a single i_step pulse -> exactly one advance; HALT_OP fetched at 0x08 -> o_halted=1, o_pc stays 0x08, state 10.
REQ-030 Reset asserted at word 7 of a load, then 2 new words loaded -> writes at addresses 0 and 4; all outputs are 0 during reset.
